// File: rtl/lcd_pcf8574_packer_pkg.sv
// lcd_pkg: shared PCF8574 bit map, FSM states, LCD opcodes and timing helpers for the LCD packer.
package lcd_pkg;
  localparam int BIT_RS = 0;
  localparam int BIT_RW = 1;
  localparam int BIT_EN = 2;
  localparam int BIT_BL = 3;
  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] HOME = 8'h02;
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, DELAY} state_t;
  function automatic int us_to_cycles(input int clk_hz, input int us);
    return clk_hz / 1_000_000 * us;
  endfunction
  function automatic logic [7:0] pcf_byte(input logic [3:0] nib, input logic bl, input logic en, input logic rs);
    logic [7:0] b;
    b = '0;
    b[7:4] = nib;
    b[BIT_BL] = bl;
    b[BIT_EN] = en;
    b[BIT_RW] = 1'b0;
    b[BIT_RS] = rs;
    return b;
  endfunction
endpackage

// File: rtl/lcd_pcf8574_packer_if.sv
// lcd_pcf8574_packer_if: command handshake from the sequencer plus byte handshake to master_i2c.
interface lcd_pcf8574_packer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_rs;
  logic       cmd_nib;
  logic       i2c_valid;
  logic       i2c_ready;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_byte;
  logic       i2c_done;
  logic       i2c_nack;
  modport slave (
    input  cmd_valid, cmd_data, cmd_rs, cmd_nib, i2c_ready, i2c_done, i2c_nack,
    output cmd_ready, i2c_valid, i2c_addr, i2c_byte
  );
  modport master (
    output cmd_valid, cmd_data, cmd_rs, cmd_nib, i2c_ready, i2c_done, i2c_nack,
    input  cmd_ready, i2c_valid, i2c_addr, i2c_byte
  );
endinterface

// File: rtl/lcd_pcf8574_packer_delay_timer.sv
// lcd_delay_timer: loadable down-counter that parks at zero; expired is high whenever the count is zero.
module lcd_delay_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  // Load has priority; otherwise count down and stop at zero.
  always_comb cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  // Counter register.
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == '0;
endmodule

// File: rtl/lcd_pcf8574_packer.sv
// lcd_pcf8574_packer: expands LCD bytes into 4-bit PCF8574 EN-strobed bytes for master_i2c, then waits the HD44780 execution time. Optional LCD_BACKLIGHT_CTRL_EN adds bl_on.
module lcd_pcf8574_packer
  import lcd_pkg::*;
#(
  parameter int         CLK_HZ   = 50_000_000,
  parameter logic [6:0] I2C_ADDR = 7'h27,
  parameter int         SHORT_US = 50,
  parameter int         LONG_US  = 2000
) (
  input  logic clk,
  input  logic rst_n,
`ifdef LCD_BACKLIGHT_CTRL_EN
  input  logic bl_on,
`endif
  lcd_pcf8574_packer_if.slave bus,
  output logic busy,
  output logic nack_err
);
  localparam int SHORT_CYC = us_to_cycles(CLK_HZ, SHORT_US);
  localparam int LONG_CYC  = us_to_cycles(CLK_HZ, LONG_US);
  localparam int CW = (LONG_CYC > 2) ? $clog2(LONG_CYC) : 1;
  state_t state_q, state_d;
  logic [7:0] data_q, data_d;
  logic rs_q, rs_d, nib_q, nib_d, long_q, long_d;
  logic [1:0] idx_q, idx_d;
  logic cmd_ready_q, cmd_ready_d, i2c_valid_q, i2c_valid_d, nack_err_q, nack_err_d;
  logic [7:0] i2c_byte_q, i2c_byte_d;
  logic accept, last, timer_load, expired, bl;
  logic [3:0] nib;
  assign accept = bus.cmd_valid && cmd_ready_q;
`ifdef LCD_BACKLIGHT_CTRL_EN
  localparam logic [7:0] RST_BYTE = 8'h00;
  logic bl_q, bl_d;
  assign bl_d = accept ? bl_on : bl_q;
  // Backlight level is captured per command so every byte of it agrees.
  always_ff @(posedge clk)
    if (!rst_n) bl_q <= 1'b0;
    else bl_q <= bl_d;
  assign bl = bl_q;
`else
  localparam logic [7:0] RST_BYTE = 8'h08;
  assign bl = 1'b1;
`endif
  // Next-state and output decode for the expand/send/wait/delay sequence.
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    rs_d = rs_q;
    nib_d = nib_q;
    long_d = long_q;
    idx_d = idx_q;
    i2c_valid_d = i2c_valid_q;
    i2c_byte_d = i2c_byte_q;
    nack_err_d = nack_err_q;
    timer_load = 1'b0;
    nib = idx_q[1] ? data_q[3:0] : data_q[7:4];
    last = nib_q ? idx_q == 2'd1 : idx_q == 2'd3;
    case (state_q)
      IDLE: if (accept) begin
        data_d = bus.cmd_data;
        rs_d = bus.cmd_rs;
        nib_d = bus.cmd_nib;
        long_d = !bus.cmd_rs && (bus.cmd_data == CLEAR || bus.cmd_data[7:1] == HOME[7:1]);
        idx_d = 2'd0;
        state_d = LOAD;
      end
      LOAD: begin
        i2c_byte_d = pcf_byte(nib, bl, ~idx_q[0], rs_q);
        i2c_valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: if (bus.i2c_ready) begin
        i2c_valid_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: if (bus.i2c_done) begin
        if (bus.i2c_nack) begin
          nack_err_d = 1'b1;
          state_d = IDLE;
        end else if (last) begin
          timer_load = 1'b1;
          state_d = DELAY;
        end else begin
          idx_d = idx_q + 2'd1;
          state_d = LOAD;
        end
      end
      DELAY: state_d = expired ? IDLE : DELAY;
      default: state_d = IDLE;
    endcase
    cmd_ready_d = state_d == IDLE;
  end
  // State and registered outputs; reset discards any command in flight.
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      data_q <= '0;
      rs_q <= 1'b0;
      nib_q <= 1'b0;
      long_q <= 1'b0;
      idx_q <= '0;
      cmd_ready_q <= 1'b0;
      i2c_valid_q <= 1'b0;
      i2c_byte_q <= RST_BYTE;
      nack_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      rs_q <= rs_d;
      nib_q <= nib_d;
      long_q <= long_d;
      idx_q <= idx_d;
      cmd_ready_q <= cmd_ready_d;
      i2c_valid_q <= i2c_valid_d;
      i2c_byte_q <= i2c_byte_d;
      nack_err_q <= nack_err_d;
    end
  lcd_delay_timer #(.W(CW)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(timer_load),
    .load_val(CW'(long_q ? LONG_CYC - 1 : SHORT_CYC - 1)),
    .expired(expired)
  );
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.i2c_valid = i2c_valid_q;
  assign bus.i2c_byte = i2c_byte_q;
  assign bus.i2c_addr = I2C_ADDR;
  assign busy = state_q != IDLE;
  assign nack_err = nack_err_q;
endmodule
